// File: rtl/resp_packet_tx.sv
// Response packet framer: serialises an opcode plus a result word or an
// echoed byte stream into the parser's wire format (opcode, reserved,
// length LSB, length MSB, payload), one byte per valid/ready transfer.
module resp_packet_tx #(
  parameter logic [7:0]  RESERVED_BYTE_P = 8'h00,
  parameter int unsigned HDR_LEN_P       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  output logic        ready_o,
  input  logic [7:0]  opcode_i,
  input  logic        mode_i,
  input  logic [31:0] result_i,
  input  logic [15:0] len_i,
  input  logic [7:0]  stream_data_i,
  input  logic        stream_valid_i,
  output logic        stream_yumi_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        done_o,
  output logic        busy_o
);

  localparam int unsigned LEN_W      = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  // Largest stream payload whose length field (payload + header) fits 16 bits
  localparam logic [LEN_W-1:0] MAX_PAY = LEN_W'(65535 - HDR_LEN_P);
  localparam logic [LEN_W-1:0] HDR_LEN = LEN_W'(HDR_LEN_P);
  localparam logic [LEN_W-1:0] WORD_PAY = LEN_W'(WORD_BYTES);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] OPC  = 3'd1;
  localparam logic [2:0] RSV  = 3'd2;
  localparam logic [2:0] LSB  = 3'd3;
  localparam logic [2:0] MSB  = 3'd4;
  localparam logic [2:0] PAY  = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  logic [2:0]        state_q,    state_d;
  logic              mode_q,     mode_d;
  logic [WORD_W-1:0] result_q,   result_d;
  logic [LEN_W-1:0]  pcount_q,   pcount_d;
  logic [LEN_W-1:0]  cnt_q,      cnt_d;
  logic [BYTE_W-1:0] byte_q,     byte_d;
  logic              tx_valid_q, tx_valid_d;
  logic              done_q,     done_d;
  logic              busy_q,     busy_d;
  logic              ready_q,    ready_d;

  logic              stream_pay;
  logic              xfer;
  logic              pay_last;
  logic [LEN_W-1:0]  len_field;
  logic [LEN_W-1:0]  cnt_inc;
  logic [LEN_W-1:0]  clamped_len;

  // Little-endian byte lane of the captured result word
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [1:0]        idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Stream payload bypasses the byte register; everything else is registered
  assign stream_pay    = (state_q == PAY) && mode_q;
  assign tx_valid_o    = stream_pay ? stream_valid_i : tx_valid_q;
  assign tx_data_o     = stream_pay ? stream_data_i  : byte_q;
  assign stream_yumi_o = stream_pay & stream_valid_i & tx_ready_i;
  assign xfer          = tx_valid_o & tx_ready_i;
  assign ready_o       = ready_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;

  // Length arithmetic shared by the header and payload states
  always_comb begin
    clamped_len = (len_i > MAX_PAY) ? MAX_PAY : len_i;
    len_field   = pcount_q + HDR_LEN;
    cnt_inc     = cnt_q + LEN_W'(1);
    pay_last    = (cnt_inc == pcount_q);
  end

  // Next-state, capture and byte-register selection
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    result_d = result_q;
    pcount_d = pcount_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d   = mode_i;
          result_d = result_i;
          pcount_d = mode_i ? clamped_len : WORD_PAY;
          byte_d   = opcode_i;
          state_d  = OPC;
        end
      end
      OPC: begin
        if (xfer) begin
          byte_d  = RESERVED_BYTE_P;
          state_d = RSV;
        end
      end
      RSV: begin
        if (xfer) begin
          byte_d  = len_field[7:0];
          state_d = LSB;
        end
      end
      LSB: begin
        if (xfer) begin
          byte_d  = len_field[15:8];
          state_d = MSB;
        end
      end
      MSB: begin
        if (xfer) begin
          cnt_d = '0;
          if (pcount_q == '0) begin
            state_d = DONE;
          end else begin
            byte_d  = word_byte(result_q, 2'd0);
            state_d = PAY;
          end
        end
      end
      PAY: begin
        if (xfer) begin
          cnt_d = cnt_inc;
          if (pay_last) begin
            state_d = DONE;
          end else begin
            byte_d = word_byte(result_q, cnt_inc[1:0]);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered status outputs decoded from the upcoming state
  always_comb begin
    tx_valid_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = 1'b0;
    ready_d    = 1'b0;
    case (state_d)
      OPC, RSV, LSB, MSB: tx_valid_d = 1'b1;
      PAY:                tx_valid_d = !mode_d;
      default:            tx_valid_d = 1'b0;
    endcase
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      result_q   <= '0;
      pcount_q   <= '0;
      cnt_q      <= '0;
      byte_q     <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      result_q   <= result_d;
      pcount_q   <= pcount_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

endmodule

// File: tb/tb_resp_packet_tx.sv
// Bench for resp_packet_tx: directed and random requests checked against a
// packet-level model (expected byte list built from the framing rules).
module tb_resp_packet_tx;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        ready_o;
  logic [7:0]  opcode_i;
  logic        mode_i;
  logic [31:0] result_i;
  logic [15:0] len_i;
  logic [7:0]  stream_data_i;
  logic        stream_valid_i;
  logic        stream_yumi_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        done_o;
  logic        busy_o;

  resp_packet_tx dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .ready_o        (ready_o),
    .opcode_i       (opcode_i),
    .mode_i         (mode_i),
    .result_i       (result_i),
    .len_i          (len_i),
    .stream_data_i  (stream_data_i),
    .stream_valid_i (stream_valid_i),
    .stream_yumi_o  (stream_yumi_o),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i),
    .done_o         (done_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] rx_q[$];
  int         rx_cyc_q[$];

  logic bp_en, gap_en, ign_en;
  logic prev_stall;
  logic [7:0] prev_data;
  logic s_valid, s_ready, s_busy, s_done;
  logic [7:0] s_data;
  int   yumi_cnt, done_cnt, done_cyc;
  logic done_ready, done_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs at negedge, sample outputs 1 unit later, retire at posedge
  task automatic step();
    logic yumi_s;
    @(negedge clk);
    start_i    = ign_en && busy_o && ($urandom_range(0, 1) == 1);
    opcode_i   = 8'($urandom);
    mode_i     = 1'($urandom);
    result_i   = $urandom;
    len_i      = 16'($urandom);
    tx_ready_i = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (src_q.size() > 0) begin
      stream_data_i  = src_q[0];
      stream_valid_i = gap_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end else begin
      stream_data_i  = 8'($urandom);
      stream_valid_i = 1'b0;
    end
    #1;
    s_valid = tx_valid_o;
    s_data  = tx_data_o;
    s_ready = ready_o;
    s_busy  = busy_o;
    s_done  = done_o;
    if (prev_stall && s_valid) chk("stable_data", 32'(s_data), 32'(prev_data));
    prev_stall = s_valid && !tx_ready_i;
    prev_data  = s_data;
    if (s_valid && tx_ready_i) begin
      rx_q.push_back(s_data);
      rx_cyc_q.push_back(cyc);
    end
    yumi_s = stream_yumi_o;
    if (yumi_s) yumi_cnt++;
    if (s_done) begin
      done_cnt++;
      done_cyc   = cyc;
      done_ready = s_ready;
      done_busy  = s_busy;
    end
    @(posedge clk);
    cyc++;
    if (yumi_s && src_q.size() > 0) void'(src_q.pop_front());
  endtask

  // Build the expected wire bytes for a request and load the stream source
  task automatic prep_pkt(input logic [7:0] op, input logic md, input logic [31:0] res,
                          input logic [15:0] ln, output int p);
    logic [15:0] lf;
    logic [7:0]  b;
    p  = md ? ((ln > 16'd65531) ? 65531 : int'(ln)) : 4;
    lf = 16'(p + 4);
    exp_q.delete();
    src_q.delete();
    rx_q.delete();
    rx_cyc_q.delete();
    exp_q.push_back(op);
    exp_q.push_back(8'h00);
    exp_q.push_back(lf[7:0]);
    exp_q.push_back(lf[15:8]);
    if (!md) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(res[8*i +: 8]);
    end else begin
      for (int i = 0; i < p; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        src_q.push_back(b);
      end
    end
    yumi_cnt   = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    prev_stall = 1'b0;
  endtask

  // Present a request for one cycle and check first-byte latency
  task automatic issue(input string tag, input logic [7:0] op, input logic md,
                       input logic [31:0] res, input logic [15:0] ln);
    @(negedge clk);
    chk({tag, "_ready_before"}, 32'(ready_o), 32'd1);
    start_i        = 1'b1;
    opcode_i       = op;
    mode_i         = md;
    result_i       = res;
    len_i          = ln;
    stream_valid_i = 1'b0;
    @(posedge clk);
    cyc++;
    step();
    chk({tag, "_first_valid"}, 32'(s_valid), 32'd1);
    chk({tag, "_first_byte"}, 32'(s_data), 32'(op));
  endtask

  task automatic run_pkt(input string tag, input logic [7:0] op, input logic md,
                         input logic [31:0] res, input logic [15:0] ln,
                         input logic bp, input logic gap, input logic ign);
    int p;
    int n;
    int bad_idx;
    int nrx;
    prep_pkt(op, md, res, ln, p);
    bp_en  = bp;
    gap_en = gap;
    ign_en = ign;
    issue(tag, op, md, res, ln);
    n = 0;
    while (done_cnt == 0 && n < 4 * (p + 8) + 50) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    if (done_cnt != 0) begin
      chk({tag, "_ready_in_done"}, 32'(done_ready), 32'd0);
      chk({tag, "_busy_in_done"}, 32'(done_busy), 32'd1);
    end
    ign_en = 1'b0;
    step();
    chk({tag, "_ready_after"}, 32'(s_ready), 32'd1);
    chk({tag, "_busy_after"}, 32'(s_busy), 32'd0);
    chk({tag, "_byte_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    bad_idx = -1;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (bad_idx < 0 && rx_q[i] !== exp_q[i]) bad_idx = i;
    chk({tag, "_first_bad_idx"}, 32'(bad_idx), 32'hFFFF_FFFF);
    chk({tag, "_yumi_count"}, 32'(yumi_cnt), md ? 32'(p) : 32'd0);
    if (rx_q.size() > 0 && done_cnt != 0)
      chk({tag, "_done_latency"}, 32'(done_cyc - rx_cyc_q[rx_q.size()-1]), 32'd1);
    if (!bp && !gap && rx_q.size() > 0)
      chk({tag, "_back_to_back"}, 32'(rx_cyc_q[rx_q.size()-1] - rx_cyc_q[0]),
          32'(rx_q.size() - 1));
    if (ign) begin
      nrx = rx_q.size();
      repeat (12) step();
      chk({tag, "_no_second_pkt"}, 32'(rx_q.size()), 32'(nrx));
      chk({tag, "_no_second_done"}, 32'(done_cnt), 32'd1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int n;
    rst            = 1'b0;
    start_i        = 1'b0;
    opcode_i       = '0;
    mode_i         = 1'b0;
    result_i       = '0;
    len_i          = '0;
    stream_data_i  = '0;
    stream_valid_i = 1'b0;
    tx_ready_i     = 1'b1;
    bp_en          = 1'b0;
    gap_en         = 1'b0;
    ign_en         = 1'b0;
    prev_stall     = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_tx_data", 32'(tx_data_o), 32'd0);
    chk("rst_yumi", 32'(stream_yumi_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_ready", 32'(ready_o), 32'd1);

    // Directed word packet at full rate
    run_pkt("word_dir", 8'h11, 1'b0, 32'h1234_5678, 16'd0, 1'b0, 1'b0, 1'b0);

    // Same word under backpressure, with starts pulsed while busy
    run_pkt("word_bp", 8'h11, 1'b0, 32'h1234_5678, 16'd0, 1'b1, 1'b0, 1'b1);

    // Stream of three bytes with source gaps
    run_pkt("stream3", 8'h11, 1'b1, 32'h0, 16'd3, 1'b0, 1'b1, 1'b0);

    // Zero-length stream: header only
    run_pkt("stream0", 8'h11, 1'b1, 32'h0, 16'd0, 1'b1, 1'b0, 1'b0);

    // Random word and stream requests
    for (int k = 0; k < 6; k++)
      run_pkt("word_rnd", 8'($urandom), 1'b0, $urandom, 16'($urandom), 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++)
      run_pkt("stream_rnd", 8'($urandom), 1'b1, $urandom, 16'($urandom_range(1, 24)),
              1'b1, 1'b1, 1'b1);

    // Reset in the middle of a stream payload
    prep_pkt(8'h5A, 1'b1, 32'h0, 16'd10, p);
    bp_en  = 1'b0;
    gap_en = 1'b0;
    ign_en = 1'b0;
    issue("rst_mid", 8'h5A, 1'b1, 32'h0, 16'd10);
    n = 0;
    while (rx_q.size() < 7 && n < 40) begin
      step();
      n++;
    end
    chk("rst_mid_reached_pay", 32'(rx_q.size() >= 7), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_mid_yumi", 32'(stream_yumi_o), 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    chk("rst_mid_tx_data", 32'(tx_data_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    src_q.delete();
    step();
    chk("rst_mid_ready", 32'(s_ready), 32'd1);
    chk("rst_mid_idle_valid", 32'(s_valid), 32'd0);
    run_pkt("after_rst", 8'hC3, 1'b0, 32'hDEAD_BEEF, 16'd0, 1'b1, 1'b0, 1'b0);

    // Length clamp: 16'hFFFF becomes 65531 payload bytes
    run_pkt("clamp", 8'h11, 1'b1, 32'h0, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/resp_packet_tx.md
Name: resp_packet_tx

Overview:
- Transmit-side packet framer: the counterpart of the command-packet parser FSM.
- Takes a response request (an opcode plus an ALU result word, or a byte stream to echo) and serialises it into the same wire format the parser consumes: opcode, reserved, length LSB, length MSB, then payload.
- Emits one byte at a time over a valid/ready handshake toward the UART transmitter.

Parameters:
- RESERVED_BYTE_P, 8'h00, constant sent in the reserved header byte.
- HDR_LEN_P, 4, header size in bytes; it is included in the transmitted length field.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  reset: asynchronous assert, active-low (0 = in reset); synchronous deassert is the integrator's responsibility.
- start_i  input  1  request pulse; accepted only when ready_o=1.
- ready_o  output  1  block idle, can accept start_i.
- opcode_i  input  8  opcode byte to echo back in the header; captured on start.
- mode_i  input  1  0 = word mode (payload is result_i), 1 = stream mode (payload from stream_*); captured on start.
- result_i  input  32  ALU result; captured on start in word mode.
- len_i  input  16  stream-mode payload byte count; captured on start.
- stream_data_i  input  8  stream-mode payload byte.
- stream_valid_i  input  1  stream_data_i valid.
- stream_yumi_o  output  1  stream byte consumed this cycle.
- tx_data_o  output  8  byte to UART TX.
- tx_valid_o  output  1  tx_data_o valid.
- tx_ready_i  input  1  UART TX accepts the byte; a transfer occurs when tx_valid_o and tx_ready_i are both 1.
- done_o  output  1  one-cycle pulse after the last byte transfers.
- busy_o  output  1  high from start acceptance through the DONE cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - tx_valid_o=0, tx_data_o=0, stream_yumi_o=0, done_o=0, busy_o=0.
  - ready_o=1 once rst is released.
  - A reset mid-packet abandons the packet immediately; no partial-packet recovery.
- States are IDLE, OPC, RSV, LSB, MSB, PAY, DONE.
- IDLE:
  - ready_o=1.
  - On start_i=1, capture opcode_i, mode_i, result_i and len_i, then go to OPC.
  - start_i in any other state is ignored.
- Length and payload rules:
  - Word mode: payload = 4 bytes of result_i, little-endian (byte0 = result[7:0]).
  - Word mode: length field = 16'd8.
  - Stream mode: payload count P = min(len_i, 16'd65531).
  - Stream mode: length field = P + HDR_LEN_P, computed in 16 bits; clamping guarantees no wrap.
  - len_i above 65531 is clamped, never wrapped.
- Header states (OPC, RSV, LSB, MSB):
  - tx_valid_o=1 with the registered byte: opcode, RESERVED_BYTE_P, length[7:0], length[15:8] respectively.
  - The state advances only on a transfer.
  - tx_data_o stays stable while tx_ready_i=0.
- First byte latency: start accepted at cycle N -> tx_valid_o=1 carrying the opcode at cycle N+1.
- Throughput: one byte per cycle when tx_ready_i is held high.
- MSB exit:
  - On transfer, go to PAY if the payload count > 0.
  - If the payload count = 0 (stream mode, len_i=0), go directly to DONE.
- PAY, word mode:
  - Registered bytes selected by a 16-bit payload counter.
  - Go to DONE on the transfer of the 4th byte.
- PAY, stream mode:
  - Pass-through: tx_data_o = stream_data_i, tx_valid_o = stream_valid_i.
  - stream_yumi_o = stream_valid_i & tx_ready_i.
  - Counter increments on each transfer; go to DONE when the count reaches P.
  - stream_yumi_o is 0 in every other state.
- DONE:
  - Lasts one cycle: done_o=1, tx_valid_o=0, ready_o=0.
  - Then IDLE.
  - Minimum start-to-start spacing is therefore total bytes + 2 cycles.
- Counter: 16-bit, cleared on leaving MSB; never wraps, because P ≤ 65531.

Test Plan:
- Word mode: start with opcode 8'h11, result 32'h12345678, tx_ready_i=1 -> bytes 11,00,08,00,78,56,34,12 on consecutive cycles; done_o pulses 1 cycle after the 12; ready_o returns the next cycle.
- Backpressure: same word request, tx_ready_i toggling 1-0-1 pseudo-randomly -> identical 8-byte sequence; tx_data_o stable whenever valid && !ready; no bytes dropped or duplicated.
- Stream mode: len_i=3, stream bytes AA,BB,CC with gaps in stream_valid_i -> header 11,00,07,00 then AA,BB,CC; exactly 3 stream_yumi_o pulses; done_o pulses once.
- Zero-length stream: len_i=0 -> only 4 header bytes 11,00,04,00; stream_yumi_o never asserts; done_o pulses.
- Clamp: len_i=16'hFFFF -> length bytes FF,FF; exactly 65531 payload bytes, then done_o.
- Reset and ignored start: assert rst mid-PAY -> tx_valid_o=0 immediately; after release ready_o=1 and a new request sends a clean packet. A start_i pulsed while busy_o=1 produces no second packet.
